mac_sequencer: RTL and testbench
================================

# mac_sequencer

Control sequencer that sits directly upstream of the MAC neuron datapath. It walks the shared input/weight memories via `input_sel`, drives the accumulator clear/load strobes and the activation `ready` qualifier, and captures the activated 20-bit result. It repeats this for `NEURONS` neurons of a layer and hands each result downstream over a valid/ready handshake.

## Interface
- `N`, 10, inputs per neuron (MAC terms); legal range 1..2^16
- `NEURONS`, 4, neurons evaluated per `start`; legal range 1..256
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `start`  in  1  one-cycle request to evaluate a layer; sampled only in IDLE
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last neuron's result is accepted
- `input_sel`  out  32  index into input/weight memories
- `neuron_sel`  out  8  current neuron index, used as weight-bank select
- `rst_Acc`  out  1  accumulator clear strobe
- `ld_Acc`  out  1  accumulator load enable
- `ready`  out  1  activation qualifier; MAC result is valid while high
- `mac_result`  in  20  activated accumulator value from the MAC
- `out_valid`  out  1  `out_data` holds a result
- `out_ready`  in  1  downstream accepts the result
- `out_data`  out  20  captured neuron result
- `out_index`  out  8  neuron index of `out_data`

## Operation
- The FSM has the states IDLE, CLEAR, ACCUM, ACT, EMIT and DONE. All outputs decode from registered state or come from flops, so none depends combinationally on an input.
- IDLE: `start`=1 -> CLEAR and `neuron_sel`<=0. Otherwise the FSM stays in IDLE.
- CLEAR: `rst_Acc`=1 for exactly one cycle and `input_sel`=0. The FSM then enters ACCUM with the term counter at 0.
- ACCUM: `ld_Acc`=1 and `input_sel`=term counter. The counter increments 0..N-1, so there is one accumulate per cycle. After the cycle with `input_sel`=N-1 the FSM moves to ACT.
- ACT: `ready`=1 for one cycle and `ld_Acc`=0. `mac_result` is captured into `out_data` at the closing edge, and `out_index`<=`neuron_sel`. The FSM then enters EMIT.
- EMIT: `out_valid`=1, and `out_data`/`out_index` are held stable until `out_valid && out_ready`. On that handshake edge:
  - if `neuron_sel`=NEURONS-1, go to DONE;
  - otherwise `neuron_sel`++ and go to CLEAR.
- DONE: `done`=1 for one cycle, then the FSM returns to IDLE.
- `input_sel` is 0 outside ACCUM. Its upper bits are always zero (counter width is clog2(N), zero-extended).
- `ld_Acc`, `rst_Acc` and `ready` are mutually exclusive.

## Timing
- Reset values: state IDLE, and every output 0 (`busy`, `done`, `input_sel`, `neuron_sel`, `rst_Acc`, `ld_Acc`, `ready`, `out_valid`, `out_data`, `out_index`).
- Reset assertion mid-operation clears everything immediately (asynchronously). No result is emitted, and `done` does not pulse.
- Deassertion is sampled on `clk`; the first legal `start` is in the cycle after `rst` rises.
- Timeline, with `start` sampled at edge E0:
  - CLEAR occupies cycle 1;
  - ACCUM occupies cycles 2..N+1;
  - ACT occupies cycle N+2;
  - `out_valid` rises in cycle N+3.
- Per-neuron latency is N+3 cycles plus handshake wait. With `out_ready` tied high, a neuron takes N+3 cycles. `done` follows one cycle after the final handshake.
- `start` is ignored while `busy`=1, including in DONE. It is not queued.
- `out_ready` outside EMIT has no effect.
- `N`=1: ACCUM lasts a single cycle with `input_sel`=0.
- `NEURONS`=1: the FSM goes EMIT -> DONE directly.

## Test plan
- **Reset mid-ACCUM:** N=10, pull `rst` low during the `input_sel`=5 cycle -> all outputs 0 in the same cycle. After release, the FSM is IDLE and `done` never pulses.
- **Single neuron:** N=10, NEURONS=1, `out_ready`=1, `mac_result`=20'h00ABC during ACT, `start` at E0. Required response:
  - `rst_Acc` in cycle 1;
  - `ld_Acc` in cycles 2..11 with `input_sel` 0..9;
  - `ready` in cycle 12;
  - `out_valid` with `out_data`=20'h00ABC and `out_index`=0 in cycle 13;
  - `done` in cycle 14.
- **Backpressure:** hold `out_ready`=0 for 5 EMIT cycles -> `out_valid` stays 1 with `out_data`/`out_index` constant. No `ld_Acc`/`rst_Acc` pulses occur, and `neuron_sel` does not advance until the handshake.
- **Full layer:** N=3, NEURONS=4, `out_ready`=1, `mac_result`=neuron index+1. Required response:
  - four results with `out_index` 0,1,2,3 and `out_data` 1,2,3,4;
  - each neuron takes 6 cycles;
  - `done` at cycle 25 after `start`.
- **Ignored start:** pulse `start` during ACCUM and again during DONE -> no restart and no extra `rst_Acc`. The FSM returns to IDLE and waits for a fresh `start`.
- **Degenerate size:** N=1, NEURONS=1 -> exactly one `ld_Acc` cycle with `input_sel`=0, and `ready` in cycle 3 after `start`.

Source files
------------

// File: rtl/mac_sequencer.sv
// Control sequencer for a MAC neuron datapath: per neuron it clears the
// accumulator, streams N terms, qualifies the activated result and emits it.
module mac_sequencer #(
   parameter int N       = 10,
   parameter int NEURONS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [31:0] input_sel,
   output logic [7:0]  neuron_sel,
   output logic        rst_Acc,
   output logic        ld_Acc,
   output logic        ready,
   input  logic [19:0] mac_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [19:0] out_data,
   output logic [7:0]  out_index
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_TERM   = CW'(N - 1);
   localparam logic [7:0]    LAST_NEURON = 8'(NEURONS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ACCUM,
      S_ACT,
      S_EMIT,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   term_q, term_d;
   logic [7:0]      neuron_q, neuron_d;
   logic [19:0]     data_q, data_d;
   logic [7:0]      index_q, index_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         term_q   <= '0;
         neuron_q <= '0;
         data_q   <= '0;
         index_q  <= '0;
      end else begin
         state_q  <= state_d;
         term_q   <= term_d;
         neuron_q <= neuron_d;
         data_q   <= data_d;
         index_q  <= index_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      term_d   = term_q;
      neuron_d = neuron_q;
      data_d   = data_q;
      index_d  = index_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_CLEAR;
               neuron_d = '0;
            end
         end
         S_CLEAR: begin
            term_d  = '0;
            state_d = S_ACCUM;
         end
         S_ACCUM: begin
            if (term_q == LAST_TERM) begin
               term_d  = '0;
               state_d = S_ACT;
            end else begin
               term_d = term_q + 1'b1;
            end
         end
         S_ACT: begin
            // The MAC result is only meaningful while ready is high, so capture here.
            data_d  = mac_result;
            index_d = neuron_q;
            state_d = S_EMIT;
         end
         S_EMIT: begin
            if (out_ready) begin
               if (neuron_q == LAST_NEURON) begin
                  state_d = S_DONE;
               end else begin
                  neuron_d = neuron_q + 1'b1;
                  state_d  = S_CLEAR;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Every output is a pure decode of registered state, never of an input.
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign rst_Acc    = (state_q == S_CLEAR);
   assign ld_Acc     = (state_q == S_ACCUM);
   assign ready      = (state_q == S_ACT);
   assign out_valid  = (state_q == S_EMIT);
   assign input_sel  = (state_q == S_ACCUM) ? {{(32-CW){1'b0}}, term_q} : 32'd0;
   assign neuron_sel = neuron_q;
   assign out_data   = data_q;
   assign out_index  = index_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: three instances cover N=10/NEURONS=1,
// N=3/NEURONS=4 and the N=1/NEURONS=1 degenerate case.
module tb_mac_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // flag vector order: {busy, done, rst_Acc, ld_Acc, ready, out_valid}
   localparam logic [5:0] F_IDLE = 6'b000000;
   localparam logic [5:0] F_CLR  = 6'b101000;
   localparam logic [5:0] F_ACC  = 6'b100100;
   localparam logic [5:0] F_ACT  = 6'b100010;
   localparam logic [5:0] F_EMIT = 6'b100001;
   localparam logic [5:0] F_DONE = 6'b110000;

   logic        start_a, out_ready_a, busy_a, done_a, rst_acc_a, ld_acc_a, ready_a, out_valid_a;
   logic [19:0] mac_result_a, out_data_a;
   logic [31:0] input_sel_a;
   logic [7:0]  neuron_sel_a, out_index_a;

   logic        start_b, out_ready_b, busy_b, done_b, rst_acc_b, ld_acc_b, ready_b, out_valid_b;
   logic [19:0] mac_result_b, out_data_b;
   logic [31:0] input_sel_b;
   logic [7:0]  neuron_sel_b, out_index_b;

   logic        start_c, out_ready_c, busy_c, done_c, rst_acc_c, ld_acc_c, ready_c, out_valid_c;
   logic [19:0] mac_result_c, out_data_c;
   logic [31:0] input_sel_c;
   logic [7:0]  neuron_sel_c, out_index_c;

   wire [5:0] flags_a = {busy_a, done_a, rst_acc_a, ld_acc_a, ready_a, out_valid_a};
   wire [5:0] flags_b = {busy_b, done_b, rst_acc_b, ld_acc_b, ready_b, out_valid_b};
   wire [5:0] flags_c = {busy_c, done_c, rst_acc_c, ld_acc_c, ready_c, out_valid_c};

   mac_sequencer #(.N(10), .NEURONS(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
      .input_sel(input_sel_a), .neuron_sel(neuron_sel_a), .rst_Acc(rst_acc_a),
      .ld_Acc(ld_acc_a), .ready(ready_a), .mac_result(mac_result_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
      .out_index(out_index_a)
   );

   mac_sequencer #(.N(3), .NEURONS(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
      .input_sel(input_sel_b), .neuron_sel(neuron_sel_b), .rst_Acc(rst_acc_b),
      .ld_Acc(ld_acc_b), .ready(ready_b), .mac_result(mac_result_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
      .out_index(out_index_b)
   );

   mac_sequencer #(.N(1), .NEURONS(1)) dut_c (
      .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
      .input_sel(input_sel_c), .neuron_sel(neuron_sel_c), .rst_Acc(rst_acc_c),
      .ld_Acc(ld_acc_c), .ready(ready_c), .mac_result(mac_result_c),
      .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c),
      .out_index(out_index_c)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, obs);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [5:0] ef;
      int         clr_cnt, ld_cnt, bad_cnt, k, p, guard;
      logic       seen;

      rst = 1'b0;
      start_a = 0; out_ready_a = 0; mac_result_a = '0;
      start_b = 0; out_ready_b = 0; mac_result_b = '0;
      start_c = 0; out_ready_c = 0; mac_result_c = '0;

      // Reset state
      #2;
      check("rst flags", 32'(flags_a), 32'(F_IDLE));
      check("rst input_sel", input_sel_a, 32'd0);
      check("rst neuron_sel", 32'(neuron_sel_a), 32'd0);
      check("rst out_data", 32'(out_data_a), 32'd0);
      check("rst out_index", 32'(out_index_a), 32'd0);
      step();
      step();
      rst = 1'b1;
      step();

      // Single neuron, N=10
      out_ready_a  = 1'b1;
      mac_result_a = 20'h00ABC;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         if (c == 1)       ef = F_CLR;
         else if (c <= 11) ef = F_ACC;
         else if (c == 12) ef = F_ACT;
         else if (c == 13) ef = F_EMIT;
         else if (c == 14) ef = F_DONE;
         else              ef = F_IDLE;
         check($sformatf("single c%0d flags", c), 32'(flags_a), 32'(ef));
         check($sformatf("single c%0d input_sel", c), input_sel_a,
               (c >= 2 && c <= 11) ? 32'(c - 2) : 32'd0);
         if (c == 13) begin
            check("single out_data", 32'(out_data_a), 32'h00ABC);
            check("single out_index", 32'(out_index_a), 32'd0);
         end
         step();
      end

      // Ignored start during ACCUM (cycle 3) and DONE (cycle 14)
      clr_cnt = 0;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         if (rst_acc_a) clr_cnt++;
         if (c == 4) begin
            check("ign c4 flags", 32'(flags_a), 32'(F_ACC));
            check("ign c4 input_sel", input_sel_a, 32'd2);
         end
         if (c == 14) check("ign c14 flags", 32'(flags_a), 32'(F_DONE));
         if (c >= 15) check($sformatf("ign c%0d flags", c), 32'(flags_a), 32'(F_IDLE));
         start_a = (c == 3 || c == 14);
         step();
      end
      start_a = 1'b0;
      check("ign clear pulses", 32'(clr_cnt), 32'd1);

      // Full layer, N=3, NEURONS=4: neuron k occupies cycles 6k+1..6k+6
      out_ready_b = 1'b1;
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      for (int c = 1; c <= 26; c++) begin
         k = (c - 1) / 6;
         p = (c - 1) % 6;
         if (c == 25)      ef = F_DONE;
         else if (c == 26) ef = F_IDLE;
         else if (p == 0)  ef = F_CLR;
         else if (p <= 3)  ef = F_ACC;
         else if (p == 4)  ef = F_ACT;
         else              ef = F_EMIT;
         mac_result_b = 20'(k + 1);
         check($sformatf("layer c%0d flags", c), 32'(flags_b), 32'(ef));
         check($sformatf("layer c%0d input_sel", c), input_sel_b,
               (c <= 24 && p >= 1 && p <= 3) ? 32'(p - 1) : 32'd0);
         if (c <= 24) check($sformatf("layer c%0d neuron_sel", c), 32'(neuron_sel_b), 32'(k));
         if (c <= 24 && p == 5) begin
            check($sformatf("layer n%0d out_data", k), 32'(out_data_b), 32'(k + 1));
            check($sformatf("layer n%0d out_index", k), 32'(out_index_b), 32'(k));
         end
         step();
      end

      // Backpressure: five EMIT cycles with out_ready low
      out_ready_b  = 1'b0;
      mac_result_b = 20'h12345;
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      repeat (4) step();
      check("bp c5 flags", 32'(flags_b), 32'(F_ACT));
      step();
      mac_result_b = 20'h0DEAD;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp e%0d flags", i), 32'(flags_b), 32'(F_EMIT));
         check($sformatf("bp e%0d out_data", i), 32'(out_data_b), 32'h12345);
         check($sformatf("bp e%0d out_index", i), 32'(out_index_b), 32'd0);
         check($sformatf("bp e%0d neuron_sel", i), 32'(neuron_sel_b), 32'd0);
         if (i == 4) out_ready_b = 1'b1;
         step();
      end
      check("bp after flags", 32'(flags_b), 32'(F_CLR));
      check("bp after neuron_sel", 32'(neuron_sel_b), 32'd1);
      seen = 1'b0;
      guard = 0;
      while (!seen && guard < 60) begin
         if (done_b) seen = 1'b1;
         guard++;
         step();
      end
      check("bp done seen", 32'(seen), 32'd1);

      // Reset asserted during the input_sel=5 cycle
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      repeat (6) step();
      check("mid input_sel pre", input_sel_a, 32'd5);
      #2;
      rst = 1'b0;
      #1;
      check("mid flags", 32'(flags_a), 32'(F_IDLE));
      check("mid input_sel", input_sel_a, 32'd0);
      check("mid out_data", 32'(out_data_a), 32'd0);
      check("mid out_index", 32'(out_index_a), 32'd0);
      check("mid b out_data", 32'(out_data_b), 32'd0);
      check("mid b neuron_sel", 32'(neuron_sel_b), 32'd0);
      step();
      step();
      rst = 1'b1;
      bad_cnt = 0;
      for (int c = 0; c < 15; c++) begin
         step();
         if (done_a || busy_a) bad_cnt++;
      end
      check("mid post idle", 32'(bad_cnt), 32'd0);

      // Degenerate N=1, NEURONS=1
      out_ready_c  = 1'b1;
      mac_result_c = 20'hFFFFF;
      ld_cnt = 0;
      start_c = 1'b1;
      step();
      start_c = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         if (ld_acc_c) ld_cnt++;
         case (c)
            1:       ef = F_CLR;
            2:       ef = F_ACC;
            3:       ef = F_ACT;
            4:       ef = F_EMIT;
            5:       ef = F_DONE;
            default: ef = F_IDLE;
         endcase
         check($sformatf("deg c%0d flags", c), 32'(flags_c), 32'(ef));
         check($sformatf("deg c%0d input_sel", c), input_sel_c, 32'd0);
         if (c == 4) check("deg out_data", 32'(out_data_c), 32'hFFFFF);
         step();
      end
      check("deg ld cycles", 32'(ld_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
